// File: rtl/instr_fetch_queue_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue_pkg
// Shared constants and types for the RISCuin instruction fetch queue:
//   - NOP_INSTR                 : encoding presented at the queue head after reset
//   - DEFAULT_INSTR_ADDR_WIDTH  : default word-address width
//   - fetch_state_e             : fetch FSM states (IDLE / REQ / DROP)
//   - sat_inc()                 : saturating 32-bit increment for perf counters
// ----------------------------------------------------------------------------
package instr_fetch_queue_pkg;

    localparam int          DEFAULT_INSTR_ADDR_WIDTH = 10;
    localparam logic [31:0] NOP_INSTR                = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no request outstanding
        REQ  = 2'd1,  // request outstanding, data will be kept
        DROP = 2'd2   // request outstanding, data will be discarded
    } fetch_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding {pc, instruction} entries for the fetch queue.
// The head entry and its valid flag are registered so the consumer sees clean
// flop outputs; a word pushed into an empty FIFO appears on the next cycle.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear_i       : synchronous flush (wins over push and pop)
//   push_i        : write push_data_i (ignored when full)
//   push_data_i   : entry to write
//   pop_i         : consume the head (ignored when empty)
//   head_valid_o  : head entry is valid
//   head_data_o   : head entry (RESET_HEAD after reset)
//   count_o       : number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int               WIDTH      = 42,
    parameter int               DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_HEAD = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     head_valid_o,
    output logic [WIDTH-1:0]         head_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             head_valid_q, head_valid_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && head_valid_q;
    assign do_push = push_i && (count_q < FULL_CNT);

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        if (clear_i) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            head_valid_d = 1'b0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d      = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            head_valid_d = (count_d != '0);
            // The new head is the word being written when the FIFO is
            // (or becomes) empty apart from this push.
            if (do_push && (rd_ptr_d == wr_ptr_q)) begin
                head_data_d = push_data_i;
            end else if (count_d != '0) begin
                head_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge values; the combinational block above uses blocking '='.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= RESET_HEAD;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; only the count and
    // the registered head decide what is visible, so stale words are harmless.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_valid_o = head_valid_q;
    assign head_data_o  = head_data_q;
    assign count_o      = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue
// Fetch stage for the RISCuin core: issues one word-address read at a time to
// a variable-latency program memory, queues returned instructions tagged with
// their PC, and hands them to decode over a valid/ready handshake. A redirect
// flushes the queue and discards any response still in flight.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   redirect, redirect_pc : one-cycle restart request and new word address
//   instr_valid/instr/instr_pc, instr_ready : queue head handshake to decode
//   mem_req/mem_addr      : read request, held stable until mem_ack
//   mem_ack/mem_rdata     : one-cycle response for the outstanding request
//   fetch_pc              : next word address to be requested (debug)
// Optional (macro RISCUIN_FETCH_PERF_EN): saturating counters
//   perf_fetched, perf_dropped, perf_stall.
// ----------------------------------------------------------------------------
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int                          INSTR_ADDR_WIDTH = DEFAULT_INSTR_ADDR_WIDTH,
    parameter int                          DEPTH            = 4,
    parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect,
    input  logic [INSTR_ADDR_WIDTH-1:0] redirect_pc,
    output logic                        instr_valid,
    output logic [31:0]                 instr,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_pc,
    input  logic                        instr_ready,
    output logic                        mem_req,
    output logic [INSTR_ADDR_WIDTH-1:0] mem_addr,
    input  logic                        mem_ack,
    input  logic [31:0]                 mem_rdata,
`ifdef RISCUIN_FETCH_PERF_EN
    output logic [31:0]                 perf_fetched,
    output logic [31:0]                 perf_dropped,
    output logic [31:0]                 perf_stall,
`endif
    output logic [INSTR_ADDR_WIDTH-1:0] fetch_pc
);

    localparam int               AW       = INSTR_ADDR_WIDTH;
    localparam int               CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_state_e   state_q;
    logic [AW-1:0]  fetch_pc_q;
    logic [AW-1:0]  mem_addr_q;
    logic           mem_req_q;
    logic [CNT_W-1:0] fifo_count;
    logic           fifo_push;
    logic           fifo_pop;
    logic [AW+31:0] fifo_head;

    // In REQ, fetch_pc equals the outstanding address, so it tags the data.
    assign fifo_push = (state_q == REQ) && mem_ack && !redirect;
    assign fifo_pop  = instr_valid && instr_ready;

    fetch_fifo #(
        .WIDTH      (AW + 32),
        .DEPTH      (DEPTH),
        .RESET_HEAD ({{AW{1'b0}}, NOP_INSTR})
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (redirect),
        .push_i       (fifo_push),
        .push_data_i  ({fetch_pc_q, mem_rdata}),
        .pop_i        (fifo_pop),
        .head_valid_o (instr_valid),
        .head_data_o  (fifo_head),
        .count_o      (fifo_count)
    );

    assign instr    = fifo_head[31:0];
    assign instr_pc = fifo_head[AW+31:32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            case (state_q)
                IDLE: begin
                    // No push can be pending in IDLE, so the current count
                    // alone decides whether a slot is free for the reply.
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                    end else if (fifo_count < FULL_CNT) begin
                        state_q    <= REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        fetch_pc_q <= redirect ? redirect_pc : fetch_pc_q + AW'(1);
                    end else if (redirect) begin
                        state_q    <= DROP;
                        fetch_pc_q <= redirect_pc;
                    end
                end
                DROP: begin
                    if (redirect) fetch_pc_q <= redirect_pc;
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign fetch_pc = fetch_pc_q;

`ifdef RISCUIN_FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_dropped_q, perf_stall_q;
    logic        ack_taken, ack_dropped, stalled;

    // Acks arriving in IDLE belong to no request and are not counted.
    assign ack_taken   = mem_ack && (state_q != IDLE);
    assign ack_dropped = mem_ack && ((state_q == DROP) || ((state_q == REQ) && redirect));
    assign stalled     = (state_q == IDLE) && (fifo_count == FULL_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (ack_taken)   perf_fetched_q <= sat_inc(perf_fetched_q);
            if (ack_dropped) perf_dropped_q <= sat_inc(perf_dropped_q);
            if (stalled)     perf_stall_q   <= sat_inc(perf_stall_q);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
`timescale 1ns/1ps
module tb_instr_fetch_queue;

    localparam int W     = 10;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk = 1'b0;
    logic         rst;
    logic         redirect;
    logic [W-1:0] redirect_pc;
    logic         instr_valid;
    logic [31:0]  instr;
    logic [W-1:0] instr_pc;
    logic         instr_ready;
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic [W-1:0] fetch_pc;
`ifdef RISCUIN_FETCH_PERF_EN
    logic [31:0]  perf_fetched, perf_dropped, perf_stall;
`endif

    instr_fetch_queue #(
        .INSTR_ADDR_WIDTH (W),
        .DEPTH            (DEPTH),
        .RESET_PC         (10'd0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
`ifdef RISCUIN_FETCH_PERF_EN
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped),
        .perf_stall   (perf_stall),
`endif
        .fetch_pc     (fetch_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural program memory ----------------
    int lat_cfg   = 1;   // fixed ack latency; 0 selects random 1..3 per request
    int age       = 0;
    int cur_lat   = 1;
    bit rand_data = 0;
    bit spurious  = 0;   // occasional acks with no request outstanding

    function automatic logic [31:0] pattern(input logic [W-1:0] a);
        return {8'hA5, 14'h0, a};
    endfunction

    // Advance one clock; outputs are sampled 1ns after the edge, then the
    // memory decides this cycle's ack from what it sees on the request lines.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_req) begin
            if (age == 0) cur_lat = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
            age++;
            if (age > cur_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rand_data ? $urandom : pattern(mem_addr);
                age       = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end else begin
            age       = 0;
            mem_ack   = spurious && ($urandom_range(0, 15) == 0);
            mem_rdata = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; age = 0; spurious = 0; rand_data = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;   // now in cycle 0 after release
    endtask

    // ---------------- table of the zero-wait start-up sequence ----------------
    typedef struct {
        logic         ready;
        logic         exp_req;
        logic [W-1:0] exp_addr;
        logic         exp_valid;
        logic [W-1:0] exp_pc;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic r, logic q, int a, logic v, int p);
        vec_t t;
        t.ready = r; t.exp_req = q; t.exp_addr = W'(a); t.exp_valid = v; t.exp_pc = W'(p);
        return t;
    endfunction

    // ---------------- reference model for random phase ----------------
    typedef struct {
        logic [W-1:0] pc;
        logic [31:0]  data;
    } entry_t;

    entry_t       m_q[$];
    logic [W-1:0] m_pc;
    logic [W-1:0] m_addr;
    bit           m_out;
    bit           m_cancel;

    initial begin
        int           reqs;
        bit           prev, found, saw_bad, got_addr;
        logic [W-1:0] new_addr;
        int           ready_pct;
        int           sz;
        bit           pop;

        // cycles: 0 idle, 1-2 request 0, 3 head pc0, then every 3 cycles
        vecs[0]  = mk(1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 1, 0);
        vecs[4]  = mk(1, 1, 1, 0, 0);
        vecs[5]  = mk(1, 1, 1, 0, 0);
        vecs[6]  = mk(1, 0, 0, 1, 1);
        vecs[7]  = mk(1, 1, 2, 0, 0);
        vecs[8]  = mk(1, 1, 2, 0, 0);
        vecs[9]  = mk(1, 0, 0, 1, 2);
        vecs[10] = mk(1, 1, 3, 0, 0);
        vecs[11] = mk(1, 1, 3, 0, 0);
        vecs[12] = mk(1, 0, 0, 1, 3);

        // ---- reset values ----
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, NOP);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_fetch_pc", fetch_pc, 0);

        // ---- zero-wait sequential fetch, table driven ----
        do_reset();
        lat_cfg = 1;
        for (int c = 0; c < 13; c++) begin
            if (c > 0) tick();
            instr_ready = vecs[c].ready;
            check($sformatf("seq_c%0d_req", c), mem_req, vecs[c].exp_req);
            if (vecs[c].exp_req) check($sformatf("seq_c%0d_addr", c), mem_addr, vecs[c].exp_addr);
            check($sformatf("seq_c%0d_valid", c), instr_valid, vecs[c].exp_valid);
            if (vecs[c].exp_valid) begin
                check($sformatf("seq_c%0d_pc", c), instr_pc, vecs[c].exp_pc);
                check($sformatf("seq_c%0d_instr", c), instr, pattern(vecs[c].exp_pc));
            end
        end

        // ---- fill with instr_ready low ----
        do_reset();
        lat_cfg = 1;
        reqs = 0; prev = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req && !prev) reqs++;
            prev = mem_req;
        end
        check("full_req_count", reqs, 4);
        check("full_req_low", mem_req, 0);
        check("full_head_valid", instr_valid, 1);
        check("full_head_pc", instr_pc, 0);
`ifdef RISCUIN_FETCH_PERF_EN
        check("full_perf_fetched", perf_fetched, 4);
        check("full_perf_dropped", perf_dropped, 0);
        check("full_perf_stall_nz", perf_stall != 0, 1);
`endif
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("full_pop_head_pc", instr_pc, 1);
        for (int i = 0; i < 2 && !mem_req; i++) tick();
        check("full_refill_req", mem_req, 1);
        check("full_refill_addr", mem_addr, 4);

        // ---- redirect while request outstanding: DROP ----
        do_reset();
        lat_cfg = 3;
        instr_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 10'h005;
        tick();
        redirect = 1'b0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = mem_req && (mem_addr == 10'h005);
        end
        check("drop_req5_seen", found, 1);
        tick();
        redirect = 1'b1; redirect_pc = 10'h040;
        tick();
        redirect = 1'b0;
        check("drop_fetch_pc", fetch_pc, 10'h040);
        check("drop_req_held", mem_req, 1);
        check("drop_addr_held", mem_addr, 10'h005);
        saw_bad = 0; got_addr = 0; new_addr = '0;
        for (int i = 0; i < 40 && !instr_valid; i++) begin
            tick();
            if (instr_valid && instr_pc == 10'h005) saw_bad = 1;
            if (!got_addr && mem_req && mem_addr != 10'h005) begin
                got_addr = 1; new_addr = mem_addr;
            end
        end
        check("drop_no_stale_pc5", saw_bad, 0);
        check("drop_new_req_seen", got_addr, 1);
        check("drop_new_addr", new_addr, 10'h040);
        check("drop_first_valid", instr_valid, 1);
        check("drop_first_pc", instr_pc, 10'h040);
        check("drop_first_instr", instr, pattern(10'h040));

        // ---- redirect coinciding with mem_ack and a pop ----
        do_reset();
        lat_cfg = 1;
        instr_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = mem_req && mem_ack && (mem_addr == 10'h001);
        end
        check("rap_ack_seen", found, 1);
        check("rap_head_valid", instr_valid, 1);
        redirect = 1'b1; redirect_pc = 10'h100; instr_ready = 1'b1;
        tick();
        redirect = 1'b0; instr_ready = 1'b0;
        check("rap_empty", instr_valid, 0);
        check("rap_fetch_pc", fetch_pc, 10'h100);
        check("rap_req_low", mem_req, 0);
        tick();
        check("rap_req", mem_req, 1);
        check("rap_addr", mem_addr, 10'h100);
        instr_ready = 1'b1;
        for (int i = 0; i < 10 && !instr_valid; i++) tick();
        check("rap_valid", instr_valid, 1);
        check("rap_pc", instr_pc, 10'h100);

        // ---- wrap of fetch_pc ----
        do_reset();
        lat_cfg = 1;
        instr_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 10'h3FF;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 10 && !instr_valid; i++) tick();
        check("wrap_pc_top", instr_pc, 10'h3FF);
        check("wrap_instr_top", instr, pattern(10'h3FF));
        tick();
        for (int i = 0; i < 10 && !instr_valid; i++) tick();
        check("wrap_pc_zero", instr_pc, 10'h000);
        check("wrap_instr_zero", instr, pattern(10'h000));

        // ---- reset asserted during a request ----
        do_reset();
        lat_cfg = 3;
        instr_ready = 1'b0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            found = instr_valid && mem_req;
        end
        check("mid_rst_setup", found, 1);
        #2;
        rst = 1'b1; mem_ack = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_fetch_pc", fetch_pc, 0);
`ifdef RISCUIN_FETCH_PERF_EN
        check("mid_rst_perf_fetched", perf_fetched, 0);
        check("mid_rst_perf_dropped", perf_dropped, 0);
        check("mid_rst_perf_stall", perf_stall, 0);
`endif
        @(posedge clk);
        #2;
        rst = 1'b0; age = 0;
        check("post_rst_idle", mem_req, 0);
        tick();
        check("post_rst_req", mem_req, 1);
        check("post_rst_addr", mem_addr, 0);

        // ---- randomized run against the transaction model ----
        do_reset();
        lat_cfg = 0; rand_data = 1; spurious = 1;
        m_q.delete(); m_pc = '0; m_addr = '0; m_out = 0; m_cancel = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) tick();
            ready_pct   = ((c / 200) % 2 == 0) ? 75 : 15;
            instr_ready = ($urandom_range(0, 99) < ready_pct);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? W'(10'h3FE + $urandom_range(0, 1)) : W'($urandom);

            check("rnd_valid", instr_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                check("rnd_pc", instr_pc, m_q[0].pc);
                check("rnd_instr", instr, m_q[0].data);
            end
            check("rnd_req", mem_req, m_out);
            if (m_out) check("rnd_addr", mem_addr, m_addr);
            check("rnd_fetch_pc", fetch_pc, m_pc);

            // apply this cycle's events to the model
            sz  = m_q.size();
            pop = (sz != 0) && instr_ready;
            if (pop) void'(m_q.pop_front());
            if (m_out && mem_ack) begin
                if (!m_cancel && !redirect) begin
                    m_q.push_back('{pc: m_addr, data: mem_rdata});
                    m_pc = W'((int'(m_addr) + 1) % (1 << W));
                end
                m_out = 0;
            end else if (!m_out && !redirect && sz < DEPTH) begin
                m_out = 1; m_addr = m_pc; m_cancel = 0;
            end else if (m_out && redirect) begin
                m_cancel = 1;
            end
            if (redirect) begin
                m_pc = redirect_pc;
                m_q.delete();
            end
        end
        redirect = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
